// File: rtl/fp_add_normalizer.sv
// fp_add_normalizer
//   Post-add normalisation stage of the floating-point adder. Takes the
//   complement adder's magnitude, its carry-out flag, the result sign and
//   the aligned exponent. It renormalises the mantissa (one right shift on
//   carry, left shifts on leading zeros), adjusts the exponent and packs an
//   IEEE-754 style word with overflow/underflow flags.
//
//   Build option: define NORM_FAST_SHIFT_EN to do the whole left shift in a
//   single cycle with a leading-zero count. Without it, the shifter moves one
//   bit per cycle. Packed results and flags are the same in both builds; only
//   the latency differs.
//
// Ports
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_valid / o_ready         upstream handshake (o_ready high in IDLE only)
//   i_sign, i_exp, i_mant     sum sign, biased pre-norm exponent, magnitude
//   i_shift_flag              carry-out: mantissa needs a 1-bit right shift
//   o_valid / i_ready         downstream handshake (o_valid high in DONE)
//   o_result                  packed {sign, exponent, fraction}
//   o_overflow, o_underflow   saturated to infinity / flushed to zero
module fp_add_normalizer #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_sign,
  input  logic [EXP_W-1:0]        i_exp,
  input  logic [MANT_W-1:0]       i_mant,
  input  logic                    i_shift_flag,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [EXP_W+MANT_W-1:0] o_result,
  output logic                    o_overflow,
  output logic                    o_underflow
);

  localparam int RES_W = EXP_W + MANT_W;
  // One spare exponent bit so the +1 / -1 adjustments never wrap.
  localparam int XW    = EXP_W + 1;
  localparam logic [XW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t                state_q, state_d;
  logic [MANT_W-1:0]     mant_q, mant_d;
  logic [XW-1:0]         exp_q, exp_d;
  logic                  sign_q, sign_d;
  logic [RES_W-1:0]      res_q, res_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

`ifdef NORM_FAST_SHIFT_EN
  localparam int LZC_W = $clog2(MANT_W + 1);

  // Leading-zero count; the highest set bit is visited last and wins.
  function automatic logic [LZC_W-1:0] lzc(input logic [MANT_W-1:0] m);
    lzc = LZC_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (m[i]) lzc = LZC_W'(MANT_W - 1 - i);
    end
  endfunction

  logic [LZC_W-1:0] lz;
  logic [XW-1:0]    lz_x;
  assign lz   = lzc(mant_q);
  assign lz_x = XW'(lz);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          sign_d  = i_sign;
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
          state_d = NORM;
          if (i_shift_flag) begin
            // Carry-out: restore the hidden one, drop the LSB.
            mant_d = {1'b1, i_mant[MANT_W-1:1]};
            exp_d  = {1'b0, i_exp} + XW'(1);
          end else begin
            mant_d = i_mant;
            exp_d  = {1'b0, i_exp};
          end
        end
      end
      NORM: begin
        if (exp_q >= EXP_MAX) begin
          res_d   = {sign_q, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
          ovf_d   = 1'b1;
          state_d = DONE;
        end else if (mant_q == '0) begin
          res_d   = {sign_q, {(RES_W-1){1'b0}}};
          state_d = DONE;
        end else if (mant_q[MANT_W-1]) begin
          res_d   = {sign_q, exp_q[EXP_W-1:0], mant_q[MANT_W-2:0]};
          state_d = DONE;
`ifdef NORM_FAST_SHIFT_EN
        end else if (exp_q <= lz_x) begin
          // Exponent would reach zero before the leading one reaches the MSB.
          res_d   = {sign_q, {(RES_W-1){1'b0}}};
          udf_d   = 1'b1;
          state_d = DONE;
        end else begin
          mant_d = mant_q << lz;
          exp_d  = exp_q - lz_x;
        end
`else
        end else if (exp_q <= XW'(1)) begin
          res_d   = {sign_q, {(RES_W-1){1'b0}}};
          udf_d   = 1'b1;
          state_d = DONE;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - XW'(1);
        end
`endif
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_ready     = (state_q == IDLE);
  assign o_valid     = (state_q == DONE);
  assign o_result    = res_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = udf_q;

endmodule

// File: tb/tb_fp_add_normalizer.sv
module tb_fp_add_normalizer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [7:0]  i_exp;
  logic [23:0] i_mant;
  logic        i_shift_flag;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_overflow;
  logic        o_underflow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        udf;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 i_clk = ~i_clk;

  fp_add_normalizer #(.MANT_W(24), .EXP_W(8)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_sign       (i_sign),
    .i_exp        (i_exp),
    .i_mant       (i_mant),
    .i_shift_flag (i_shift_flag),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result),
    .o_overflow   (o_overflow),
    .o_underflow  (o_underflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic o, input logic u, input int l);
    exp_t e;
    e.res = r; e.ovf = o; e.udf = u; e.lat = l;
    return e;
  endfunction

  // Behavioural reference: apply the normalisation rules step by step.
  function automatic exp_t ref_model(input logic s, input logic [7:0] ein,
                                     input logic [23:0] min, input logic sf);
    exp_t        r;
    logic [23:0] m;
    int          e;
    int          shifts;
    bit          normal_end;
    m = sf ? {1'b1, min[23:1]} : min;
    e = sf ? int'(ein) + 1 : int'(ein);
    shifts = 0;
    normal_end = 0;
    r = mk(32'h0, 1'b0, 1'b0, 0);
    for (int it = 0; it < 40; it++) begin
      if (e >= 255) begin
        r.res = {s, 8'hFF, 23'h0}; r.ovf = 1'b1; break;
      end else if (m == 24'h0) begin
        r.res = {s, 31'h0}; break;
      end else if (m[23]) begin
        r.res = {s, e[7:0], m[22:0]}; normal_end = 1; break;
      end else if (e <= 1) begin
        r.res = {s, 31'h0}; r.udf = 1'b1; break;
      end else begin
        m = m << 1; e = e - 1; shifts++;
      end
    end
`ifdef NORM_FAST_SHIFT_EN
    r.lat = (normal_end && shifts > 0) ? 2 : 1;
`else
    r.lat = 1 + shifts;
`endif
    return r;
  endfunction

  task automatic drive(input logic s, input logic [7:0] e, input logic [23:0] m,
                       input logic sf, input bit push, input exp_t ex);
    @(negedge i_clk);
    i_sign = s; i_exp = e; i_mant = m; i_shift_flag = sf; i_valid = 1'b1;
    if (push) sb.push_back(ex);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    exp_t ex;
    int   cyc;
    bit   got;
    cyc = 0;
    got = 0;
    ex = sb.pop_front();
    for (int c = 1; c <= 40; c++) begin
      @(posedge i_clk);
      #1;
      if (o_valid) begin cyc = c; got = 1; break; end
    end
    chk({tag, "_valid_seen"}, 64'(got), 64'(1));
    if (got) begin
      chk({tag, "_result"}, 64'(o_result), 64'(ex.res));
      chk({tag, "_ovf"}, 64'(o_overflow), 64'(ex.ovf));
      chk({tag, "_udf"}, 64'(o_underflow), 64'(ex.udf));
      chk({tag, "_latency"}, 64'(cyc), 64'(ex.lat));
      chk({tag, "_ready_low"}, 64'(o_ready), 64'(0));
      @(negedge i_clk);
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      chk({tag, "_release_valid"}, 64'(o_valid), 64'(0));
      chk({tag, "_release_ready"}, 64'(o_ready), 64'(1));
      i_ready = 1'b0;
    end
  endtask

  initial begin
    int          lat2;
    int          lat_udf;
    int          vld_seen;
    logic [31:0] held;
    logic        rs;
    logic [7:0]  re;
    logic [23:0] rm;
    logic        rf;
`ifdef NORM_FAST_SHIFT_EN
    lat2 = 2; lat_udf = 1;
`else
    lat2 = 3; lat_udf = 2;
`endif
    i_rst_n = 1'b0; i_valid = 1'b0; i_sign = 1'b0; i_exp = '0;
    i_mant = '0; i_shift_flag = 1'b0; i_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ready", 64'(o_ready), 64'(1));
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_result", 64'(o_result), 64'(0));
    chk("rst_flags", 64'({o_overflow, o_underflow}), 64'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Directed cases with hand-derived results
    drive(1'b0, 8'h7F, 24'h000000, 1'b1, 1, mk(32'h40000000, 0, 0, 1));
    collect("one_plus_one");
    drive(1'b0, 8'h80, 24'h200000, 1'b0, 1, mk(32'h3F000000, 0, 0, lat2));
    collect("two_shift");
    drive(1'b0, 8'h85, 24'h000000, 1'b0, 1, mk(32'h00000000, 0, 0, 1));
    collect("zero");
    drive(1'b1, 8'h02, 24'h000100, 1'b0, 1, mk(32'h80000000, 0, 1, lat_udf));
    collect("underflow");
    drive(1'b0, 8'hFE, 24'h400000, 1'b1, 1, mk(32'h7F800000, 1, 0, 1));
    collect("overflow");
    drive(1'b1, 8'h01, 24'h400000, 1'b0, 1, mk(32'h80000000, 0, 1, 1));
    collect("underflow_exp1");

    // Backpressure: result held in DONE, new input ignored
    drive(1'b0, 8'h7F, 24'h000000, 1'b1, 0, mk(0, 0, 0, 0));
    vld_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge i_clk);
      #1;
      if (o_valid) begin vld_seen = 1; break; end
    end
    chk("bp_valid_seen", 64'(vld_seen), 64'(1));
    held = o_result;
    chk("bp_result", 64'(held), 64'(32'h40000000));
    @(negedge i_clk);
    i_valid = 1'b1; i_sign = 1'b1; i_exp = 8'h10; i_mant = 24'h800000; i_shift_flag = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clk);
      #1;
      chk("bp_hold_result", 64'(o_result), 64'(32'h40000000));
      chk("bp_hold_state", 64'({o_valid, o_ready, o_overflow, o_underflow}), 64'(4'b1000));
    end
    @(negedge i_clk);
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    chk("bp_release", 64'({o_valid, o_ready}), 64'(2'b01));
    i_ready = 1'b0;
    @(posedge i_clk);
    #1;
    chk("bp_no_accept", 64'({o_valid, o_ready}), 64'(2'b01));

    // Reset while shifting: in-flight operand dropped
    drive(1'b0, 8'h80, 24'h000001, 1'b0, 0, mk(0, 0, 0, 0));
    @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(o_ready), 64'(1));
    chk("midrst_valid", 64'(o_valid), 64'(0));
    chk("midrst_result", 64'(o_result), 64'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    vld_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge i_clk);
      #1;
      if (o_valid) vld_seen = 1;
    end
    chk("midrst_no_valid", 64'(vld_seen), 64'(0));
    drive(1'b0, 8'h80, 24'h000001, 1'b0, 1, mk(32'h34800000, 0, 0,
`ifdef NORM_FAST_SHIFT_EN
          2
`else
          24
`endif
          ));
    collect("after_rst");

    // Random operands against the reference model
    for (int n = 0; n < 10; n++) begin
      rs = 1'($urandom);
      re = 8'($urandom_range(0, 255));
      rm = 24'($urandom) >> $urandom_range(0, 24);
      rf = 1'($urandom);
      drive(rs, re, rm, rf, 1, ref_model(rs, re, rm, rf));
      collect("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
